// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver
//   Interrupt-request side of an 8259A-compatible controller. It latches the
//   eight IR lines into IRR, masks them with IMR, resolves priority against
//   the in-service register using a rotating lowest-priority pointer, and
//   hands the winning level out as a 3-bit vector code over a two-pulse
//   INTA handshake.
//
// Ports
//   clk, rst_n      system clock, async active-low reset
//   ir[7:0]         request lines (already synchronous to clk)
//   ltim            1 = level-triggered IRR, 0 = edge-triggered
//   imr[7:0]        mask, bit n = 1 masks IRn
//   inta_pulse      one-cycle strobe per INTA bus cycle
//   eoi / seoi      non-specific / specific EOI strobes, seoi_level[2:0]
//   rotate_on_eoi   rotate lowest priority to the level cleared by EOI/AEOI
//   aeoi            automatic EOI at the second INTA
//   int_out         interrupt request to the CPU
//   vector_code     acknowledged level, qualified by one-cycle vector_valid
//   irr, isr        request and in-service registers
//
// State table
//   IDLE | waiting for the first INTA, int_out follows pending
//   ACK1 | level latched and in service, waiting for the second INTA
//   ACK2 | vector presented, returning to IDLE
module pic_priority_resolver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ir,
  input  logic       ltim,
  input  logic [7:0] imr,
  input  logic       inta_pulse,
  input  logic       eoi,
  input  logic       seoi,
  input  logic [2:0] seoi_level,
  input  logic       rotate_on_eoi,
  input  logic       aeoi,
  output logic       int_out,
  output logic [2:0] vector_code,
  output logic       vector_valid,
  output logic [7:0] irr,
  output logic [7:0] isr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] ir_prev_q;
  logic [2:0] lp_q, lp_d;
  logic [2:0] lvl_q, lvl_d;
  logic       spur_q, spur_d;
  logic       int_q, int_d;
  logic [2:0] vcode_q, vcode_d;
  logic       vvalid_q, vvalid_d;

  logic [7:0] req;
  logic       w_found, s_found;
  logic [2:0] w_lvl, s_lvl;
  logic [2:0] w_rank, s_rank;
  logic [2:0] idx;
  logic       pending;
  logic [7:0] set_mask, eoi_mask, aeoi_mask;

  assign req = irr_q & ~imr;

  // Scan from the highest-priority level (lp+1) downwards; the loop index is
  // the priority rank, so rank 0 is the highest priority.
  always_comb begin
    w_found = 1'b0;
    w_lvl   = 3'd0;
    w_rank  = 3'd0;
    s_found = 1'b0;
    s_lvl   = 3'd0;
    s_rank  = 3'd0;
    idx     = 3'd0;
    for (int r = 0; r < 8; r++) begin
      idx = lp_q + 3'(r) + 3'd1;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_lvl   = idx;
        w_rank  = 3'(r);
      end
      if (!s_found && isr_q[idx]) begin
        s_found = 1'b1;
        s_lvl   = idx;
        s_rank  = 3'(r);
      end
    end
  end

  assign pending = w_found && (!s_found || (w_rank < s_rank));

  always_comb begin
    state_d   = state_q;
    int_d     = int_q;
    vcode_d   = vcode_q;
    vvalid_d  = 1'b0;
    lvl_d     = lvl_q;
    spur_d    = spur_q;
    lp_d      = lp_q;
    set_mask  = 8'h00;
    eoi_mask  = 8'h00;
    aeoi_mask = 8'h00;

    // Edge mode: a bit sets on a rising edge and holds only while ir stays high.
    irr_d = ltim ? ir : ((irr_q | (ir & ~ir_prev_q)) & ir);

    if (seoi) begin
      eoi_mask = 8'h01 << seoi_level;
      if (rotate_on_eoi) lp_d = seoi_level;
    end else if (eoi && s_found) begin
      eoi_mask = 8'h01 << s_lvl;
      if (rotate_on_eoi) lp_d = s_lvl;
    end

    case (state_q)
      IDLE: begin
        int_d = pending;
        if (inta_pulse) begin
          int_d   = 1'b0;
          state_d = ACK1;
          if (pending) begin
            lvl_d    = w_lvl;
            spur_d   = 1'b0;
            set_mask = 8'h01 << w_lvl;
            if (!ltim) irr_d[w_lvl] = 1'b0;
          end else begin
            lvl_d  = 3'd7;
            spur_d = 1'b1;
          end
        end
      end
      ACK1: begin
        int_d = 1'b0;
        if (inta_pulse) begin
          vcode_d  = lvl_q;
          vvalid_d = 1'b1;
          state_d  = ACK2;
          if (aeoi && !spur_q) begin
            aeoi_mask = 8'h01 << lvl_q;
            // AEOI rotation overrides any EOI rotation in the same cycle.
            if (rotate_on_eoi) lp_d = lvl_q;
          end
        end
      end
      ACK2: begin
        int_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        int_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    // An INTA set beats an EOI clear of the same bit.
    isr_d = (isr_q & ~eoi_mask & ~aeoi_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      irr_q     <= 8'h00;
      isr_q     <= 8'h00;
      ir_prev_q <= 8'h00;
      lp_q      <= 3'd7;
      lvl_q     <= 3'd0;
      spur_q    <= 1'b0;
      int_q     <= 1'b0;
      vcode_q   <= 3'd0;
      vvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      ir_prev_q <= ir;
      lp_q      <= lp_d;
      lvl_q     <= lvl_d;
      spur_q    <= spur_d;
      int_q     <= int_d;
      vcode_q   <= vcode_d;
      vvalid_q  <= vvalid_d;
    end
  end

  assign int_out      = int_q;
  assign vector_code  = vcode_q;
  assign vector_valid = vvalid_q;
  assign irr          = irr_q;
  assign isr          = isr_q;

endmodule

// File: tb/tb_pic_priority_resolver.sv
module tb_pic_priority_resolver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ir = 8'h00;
  logic       ltim = 1'b0;
  logic [7:0] imr = 8'h00;
  logic       inta_pulse = 1'b0;
  logic       eoi = 1'b0;
  logic       seoi = 1'b0;
  logic [2:0] seoi_level = 3'd0;
  logic       rotate_on_eoi = 1'b0;
  logic       aeoi = 1'b0;
  logic       int_out;
  logic [2:0] vector_code;
  logic       vector_valid;
  logic [7:0] irr;
  logic [7:0] isr;

  pic_priority_resolver dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .ltim(ltim), .imr(imr),
    .inta_pulse(inta_pulse), .eoi(eoi), .seoi(seoi), .seoi_level(seoi_level),
    .rotate_on_eoi(rotate_on_eoi), .aeoi(aeoi), .int_out(int_out),
    .vector_code(vector_code), .vector_valid(vector_valid), .irr(irr), .isr(isr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int last_vec = -1;

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Priority is expressed as a rank: (n - lp - 1) mod 8, rank 0 = highest.
  int       m_irr, m_isr, m_lp, m_prev, m_int, m_phase, m_L, m_spur;
  int       sb[$];

  function automatic int best(input int v, input int lp);
    for (int r = 0; r < 8; r++) begin
      int n = (lp + 1 + r) % 8;
      if (v[n]) return n;
    end
    return -1;
  endfunction

  function automatic int rank(input int n, input int lp);
    return (n - lp + 15) % 8;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_irr = 0; m_isr = 0; m_lp = 7; m_prev = 0; m_int = 0;
      m_phase = 0; m_L = 0; m_spur = 0;
      sb.delete();
    end else begin
      int req, w, s, pend, n_irr, n_isr, n_lp, n_int, clr, aclr, setb;
      req  = m_irr & ~int'(imr) & 255;
      w    = best(req, m_lp);
      s    = best(m_isr, m_lp);
      pend = (w >= 0) && (s < 0 || rank(w, m_lp) < rank(s, m_lp));
      if (ltim) n_irr = int'(ir);
      else begin
        n_irr = 0;
        for (int n = 0; n < 8; n++)
          if (ir[n]) n_irr[n] = m_prev[n] ? m_irr[n] : 1'b1;
      end
      clr = -1; aclr = -1; setb = -1; n_lp = m_lp; n_int = 0;
      if (seoi) clr = int'(seoi_level);
      else if (eoi && s >= 0) clr = s;
      if (clr >= 0 && rotate_on_eoi) n_lp = clr;
      case (m_phase)
        0: begin
          n_int = pend;
          if (inta_pulse) begin
            n_int = 0; m_phase = 1;
            if (pend) begin
              m_L = w; m_spur = 0; setb = w;
              if (!ltim) n_irr[w] = 1'b0;
            end else begin
              m_L = 7; m_spur = 1;
            end
          end
        end
        1: begin
          if (inta_pulse) begin
            sb.push_back(m_L);
            m_phase = 2;
            if (aeoi && !m_spur) begin
              aclr = m_L;
              if (rotate_on_eoi) n_lp = m_L;
            end
          end
        end
        default: m_phase = 0;
      endcase
      n_isr = m_isr;
      if (clr >= 0)  n_isr[clr]  = 1'b0;
      if (aclr >= 0) n_isr[aclr] = 1'b0;
      if (setb >= 0) n_isr[setb] = 1'b1;
      m_irr = n_irr; m_isr = n_isr; m_lp = n_lp; m_int = n_int;
      m_prev = int'(ir);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      cmp("irr", int'(irr), m_irr);
      cmp("isr", int'(isr), m_isr);
      cmp("int_out", int'(int_out), m_int);
      cmp("vector_valid", int'(vector_valid), int'(sb.size() != 0));
      if (vector_valid && sb.size() != 0) begin
        cmp("vector_code", int'(vector_code), sb[0]);
        last_vec = int'(vector_code);
      end
      if (sb.size() != 0) void'(sb.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    ir = 8'h00; imr = 8'h00; inta_pulse = 0; eoi = 0; seoi = 0;
    rst_n = 0;
    tick(2);
    rst_n = 1;
    tick(1);
  endtask

  task automatic inta_pair();
    inta_pulse = 1; tick(1); inta_pulse = 0; tick(2);
    inta_pulse = 1; tick(1); inta_pulse = 0; tick(2);
  endtask

  task automatic pulse_eoi();
    eoi = 1; tick(1); eoi = 0;
  endtask

  initial begin
    int gap;
    tick(2);
    rst_n = 1;
    tick(1);
    cmp("reset_irr", int'(irr), 0);
    cmp("reset_isr", int'(isr), 0);
    cmp("reset_int", int'(int_out), 0);

    // basic edge-mode acknowledge of IR3
    ir = 8'h08; tick(1);
    cmp("s1_irr", int'(irr), 8'h08);
    tick(1);
    cmp("s1_int", int'(int_out), 1);
    inta_pair();
    cmp("s1_isr", int'(isr), 8'h08);
    cmp("s1_irr_clr", int'(irr), 0);
    cmp("s1_vec", last_vec, 3);

    // two simultaneous requests
    do_reset();
    ir = 8'h24; tick(3);
    inta_pair();
    cmp("s2_vec_a", last_vec, 2);
    pulse_eoi(); tick(2);
    cmp("s2_isr", int'(isr), 0);
    cmp("s2_int", int'(int_out), 1);
    inta_pair();
    cmp("s2_vec_b", last_vec, 5);

    // nesting
    do_reset();
    ir = 8'h10; tick(3);
    inta_pair();
    ir = 8'h50; tick(3);
    cmp("s3_int_low", int'(int_out), 0);
    ir = 8'h52; tick(3);
    cmp("s3_int_high", int'(int_out), 1);
    inta_pair();
    cmp("s3_isr", int'(isr), 8'h12);
    pulse_eoi();
    cmp("s3_isr_eoi", int'(isr), 8'h10);

    // rotation on EOI
    do_reset();
    rotate_on_eoi = 1;
    ir = 8'h08; tick(3);
    inta_pair();
    ir = 8'h00; pulse_eoi(); tick(1);
    ir = 8'h11; tick(3);
    inta_pair();
    cmp("s4_vec", last_vec, 4);
    rotate_on_eoi = 0;

    // AEOI with mask
    do_reset();
    aeoi = 1; imr = 8'hFE; ir = 8'h03; tick(3);
    inta_pair();
    cmp("s5_vec", last_vec, 0);
    cmp("s5_isr", int'(isr), 0);
    aeoi = 0;

    // spurious, then reset between pulses
    do_reset();
    inta_pair();
    cmp("s6_vec", last_vec, 7);
    cmp("s6_isr", int'(isr), 0);
    ir = 8'h01; tick(3);
    inta_pulse = 1; tick(1); inta_pulse = 0; tick(1);
    rst_n = 0; tick(1); rst_n = 1; tick(4);
    cmp("s6_isr_rst", int'(isr), 0);

    // randomized traffic checked by the model every cycle
    gap = 0;
    for (int b = 0; b < 6; b++) begin
      do_reset();
      ltim = 1'($urandom_range(0, 1));
      rotate_on_eoi = 1'($urandom_range(0, 1));
      aeoi = 1'($urandom_range(0, 1));
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 5) == 0) ir = ir ^ (8'h01 << $urandom_range(0, 7));
        if ($urandom_range(0, 19) == 0) imr = 8'($urandom & $urandom & $urandom);
        eoi  = ($urandom_range(0, 9) == 0);
        seoi = ($urandom_range(0, 19) == 0);
        seoi_level = 3'($urandom_range(0, 7));
        if (gap >= 2 && $urandom_range(0, 3) == 0) begin
          inta_pulse = 1; gap = 0;
        end else begin
          inta_pulse = 0; gap++;
        end
        if ($urandom_range(0, 399) == 0) rst_n = 0;
        else rst_n = 1;
        tick(1);
      end
      rst_n = 1; inta_pulse = 0; eoi = 0; seoi = 0;
      tick(3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
